tabela_scan: RTL and testbench

TABELA_SCAN -- requirements
Module: tabela_scan

---
 rtl/tabela_scan.sv | 138 +++++++++++++
 tb/tb_tabela_scan.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tabela_scan.sv
// tabela_scan: applies the eight vectors {a,b,c}=000..111 to a 3-input
// function under test, waits SETTLE cycles per vector, then samples s_in
// into table_out. When the scan completes, table_out is compared with the
// live `expected` input.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             scan request; ignored while busy
//   s_in              response of the function under test
//   expected[7:0]     reference truth table, bit i for vector i
//   a, b, c           stimulus outputs (a is the MSB of the vector index)
//   busy              scan in progress
//   done              scan complete, results valid
//   table_out[7:0]    captured truth table
//   match             table_out == expected (combinational)
//   mismatch_idx[2:0] lowest differing index, 0 on match (combinational)
module tabela_scan #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s_in,
  input  logic [7:0] expected,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [2:0] mismatch_idx
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TBL_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE_W = 2'd1,
    SAMPLE   = 2'd2,
    DONE     = 2'd3
  } state_e;

  // With no settle time each vector is sampled on the cycle after it is driven.
  localparam state_e FIRST_ST = (SETTLE == 0) ? SAMPLE : SETTLE_W;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [TBL_W-1:0]   diff;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    table_d = table_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = FIRST_ST;
        end
      end
      SETTLE_W: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Leave after exactly SETTLE cycles in this state.
        if (({1'b0, cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(SETTLE)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = s_in;
        if (idx_q == IDX_W'(7)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = FIRST_ST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stimulus is the registered vector index; it rests at 111 in DONE.
  assign a = idx_q[2];
  assign b = idx_q[1];
  assign c = idx_q[0];

  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;

  // Result compare against the live reference; lowest differing bit wins.
  assign diff  = table_q ^ expected;
  assign match = (diff == '0);

  always_comb begin
    mismatch_idx = '0;
    for (int i = TBL_W - 1; i >= 0; i--) begin
      if (diff[i]) mismatch_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_tabela_scan.sv
// Directed bench for tabela_scan: one instance with SETTLE=1 driving the
// function ~a&~b&c | a&~c | a&b (or a constant 1), one with SETTLE=0
// driving ~c.
module tb_tabela_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start0;
  logic [7:0] exp1, exp0;
  logic       tie1;

  logic       a1, b1, c1, busy1, done1, match1;
  logic [7:0] tbl1;
  logic [2:0] mi1;
  logic       a0, b0, c0, busy0, done0, match0;
  logic [7:0] tbl0;
  logic [2:0] mi0;
  logic       s1, s0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign s1 = tie1 ? 1'b1 : ((~a1 & ~b1 & c1) | (a1 & ~c1) | (a1 & b1));
  assign s0 = ~c0;

  tabela_scan #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_in(s1), .expected(exp1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .table_out(tbl1),
    .match(match1), .mismatch_idx(mi1)
  );

  tabela_scan #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .s_in(s0), .expected(exp0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .table_out(tbl0),
    .match(match0), .mismatch_idx(mi0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a scan on the SETTLE=1 instance; returns edges until done.
  task automatic scan1(output int cycles);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("start_busy", 32'(busy1), 32'd1);
    chk("start_done", 32'(done1), 32'd0);
    chk("start_tbl", 32'(tbl1), 32'h00);
    cycles = 0;
    while (!done1 && cycles < 100) begin
      step();
      cycles++;
    end
  endtask

  typedef struct {
    logic [7:0] expv;
    logic       tie;
    logic [7:0] want_tbl;
    logic       want_match;
    logic [2:0] want_idx;
  } vec_t;

  vec_t vecs[6];
  int   cyc;

  initial begin
    vecs[0] = '{8'hD2, 1'b0, 8'hD2, 1'b1, 3'd0};
    vecs[1] = '{8'hD3, 1'b0, 8'hD2, 1'b0, 3'd0};
    vecs[2] = '{8'h52, 1'b0, 8'hD2, 1'b0, 3'd7};
    vecs[3] = '{8'hD0, 1'b0, 8'hD2, 1'b0, 3'd1};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 3'd0};
    vecs[5] = '{8'h00, 1'b1, 8'hFF, 1'b0, 3'd0};

    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0;
    exp1 = 8'hD2; exp0 = 8'h55; tie1 = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_tbl", 32'(tbl1), 32'h00);
    chk("rst_abc", 32'({a1, b1, c1}), 32'd0);
    rst_n = 1'b1;
    step();

    // Vector ordering: vector i is held for edges 2i..2i+1 after start.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      chk("order_abc", 32'({a1, b1, c1}), 32'(n / 2));
      chk("order_busy", 32'(busy1), 32'd1);
      step();
    end
    chk("order_done", 32'(done1), 32'd1);
    chk("order_tbl", 32'(tbl1), 32'hD2);
    chk("done_abc", 32'({a1, b1, c1}), 32'd7);
    exp1 = 8'h52;
    #1;
    chk("live_exp_match", 32'(match1), 32'd0);
    chk("live_exp_idx", 32'(mi1), 32'd7);

    // Table-driven scans; each restarts from DONE.
    foreach (vecs[k]) begin
      exp1 = vecs[k].expv;
      tie1 = vecs[k].tie;
      scan1(cyc);
      chk("tv_cycles", 32'(cyc), 32'd16);
      chk("tv_tbl", 32'(tbl1), 32'(vecs[k].want_tbl));
      chk("tv_match", 32'(match1), 32'(vecs[k].want_match));
      chk("tv_idx", 32'(mi1), 32'(vecs[k].want_idx));
      chk("tv_busy", 32'(busy1), 32'd0);
    end
    tie1 = 1'b0;
    exp1 = 8'hD2;

    // SETTLE=0 instance: 8 cycles, ~c gives 8'h55.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("s0_cycles", 32'(cyc), 32'd8);
    chk("s0_tbl", 32'(tbl0), 32'h55);
    chk("s0_match", 32'(match0), 32'd1);

    // Start re-pulsed mid-scan is ignored.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 100) begin
      if (cyc == 4) start1 = 1'b1;
      if (cyc == 5) start1 = 1'b0;
      step();
      cyc++;
    end
    start1 = 1'b0;
    chk("restart_cycles", 32'(cyc), 32'd16);
    chk("restart_tbl", 32'(tbl1), 32'hD2);

    // Reset between edges during vector 3 clears outputs immediately.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int n = 0; n < 7; n++) step();
    chk("pre_rst_abc", 32'({a1, b1, c1}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    chk("arst_tbl", 32'(tbl1), 32'h00);
    chk("arst_abc", 32'({a1, b1, c1}), 32'd0);
    step();
    chk("arst_hold_done", 32'(done1), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done1), 32'd0);
    scan1(cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd16);
    chk("post_rst_tbl", 32'(tbl1), 32'hD2);
    chk("post_rst_match", 32'(match1), 32'd1);
    chk("post_rst_idx", 32'(mi1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
